// File: rtl/cache_ctrl_pkg.sv
// Shared types and helpers for the N-way cache controller: FSM state
// encoding, PLRU pointer directions and a priority encoder.
package cache_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHECK     = 2'd1,
        WRITEBACK = 2'd2,
        FILL      = 2'd3
    } state_t;

    // A PLRU node bit points the victim search toward lower or higher ways.
    localparam logic PLRU_LOW  = 1'b0;
    localparam logic PLRU_HIGH = 1'b1;

    // Widest vector the priority encoder accepts; callers zero-extend.
    localparam int MAX_WAYS = 64;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic int lowest_set_index(input logic [MAX_WAYS-1:0] vec);
        int idx;
        idx = 0;
        for (int i = MAX_WAYS - 1; i >= 0; i--) begin
            if (vec[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/cache_control_nway_plru.sv
// Combinational tree pseudo-LRU for one set. Nodes are heap ordered
// (node i has children 2i+1 and 2i+2, bit 0 is the root).
// bits_out: tree after an access to access_way (path points away from it).
// victim_way: way reached by following the pointers from the root.
module plru_tree
    import cache_ctrl_pkg::*;
#(
    parameter  int WAYS   = 4,
    localparam int WAY_W  = $clog2(WAYS),
    localparam int PLRU_W = WAYS - 1
) (
    input  logic [PLRU_W-1:0] bits_in,
    input  logic [WAY_W-1:0]  access_way,
    output logic [PLRU_W-1:0] bits_out,
    output logic [WAY_W-1:0]  victim_way
);

    logic [WAYS-1:0] victim_mask;

    // Update: a node on the accessed way's path is flipped to point away.
    for (genvar gi = 0; gi < PLRU_W; gi++) begin : g_node
        localparam int LVL = $clog2(gi + 2) - 1;
        localparam int OFF = gi + 1 - (1 << LVL);
        logic on_path;
        assign on_path     = ((access_way >> (WAY_W - LVL)) == WAY_W'(OFF));
        assign bits_out[gi] = on_path ? (access_way[WAY_W-1-LVL] ? PLRU_LOW : PLRU_HIGH)
                                      : bits_in[gi];
    end

    // Victim: a way is chosen when every node on its path points toward it.
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
        logic [WAY_W-1:0] match;
        for (genvar gl = 0; gl < WAY_W; gl++) begin : g_lvl
            localparam int NODE = (1 << gl) - 1 + (gi >> (WAY_W - gl));
            localparam int DIR  = (gi >> (WAY_W - 1 - gl)) & 1;
            assign match[gl] = (bits_in[NODE] == 1'(DIR));
        end
        assign victim_mask[gi] = &match;
    end

    // Exactly one way matches the walk; encode it.
    always_comb begin
        victim_way = WAY_W'(lowest_set_index(MAX_WAYS'(victim_mask)));
    end

endmodule

// File: rtl/cache_control_nway.sv
// N-way set-associative cache controller FSM with tree pseudo-LRU and
// invalid-way-first victim selection. The victim is latched on a miss so
// the datapath sees a stable way through WRITEBACK and FILL.
// Optional: CACHE_CTRL_BACK2BACK_EN keeps the FSM in CHECK after a hit so
// consecutive hits complete one per cycle.
module cache_control_nway
    import cache_ctrl_pkg::*;
#(
    parameter  int WAYS   = 4,
    localparam int WAY_W  = $clog2(WAYS),
    localparam int PLRU_W = WAYS - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read_cpu,
    input  logic              mem_write_cpu,
    output logic              mem_resp_cpu,
    input  logic [WAYS-1:0]   hit_vec,
    input  logic [WAYS-1:0]   valid_out,
    input  logic [WAYS-1:0]   dirty_out,
    input  logic [PLRU_W-1:0] plru_bits_in,
    output logic [PLRU_W-1:0] plru_bits_out,
    output logic              ld_plru,
    output logic [WAYS-1:0]   ld_tag,
    output logic [WAYS-1:0]   ld_valid,
    output logic              valid_in,
    output logic [WAYS-1:0]   ld_dirty,
    output logic              dirty_in,
    output logic [WAYS-1:0]   data_we,
    output logic              data_src_mem,
    output logic [WAY_W-1:0]  way_sel,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic              pmem_addr_sel,
    input  logic              pmem_resp
);

    state_t            state_reg;
    logic [WAY_W-1:0]  victim_reg;

    logic              req;
    logic              hit;
    logic              any_invalid;
    logic              victim_needs_wb;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  invalid_way;
    logic [WAY_W-1:0]  plru_victim;
    logic [WAY_W-1:0]  miss_victim;
    logic [PLRU_W-1:0] plru_updated;
    logic [WAYS-1:0]   hit_mask;
    logic [WAYS-1:0]   victim_mask;

    assign req             = mem_read_cpu | mem_write_cpu;
    assign hit             = |hit_vec;
    assign hit_way         = WAY_W'(lowest_set_index(MAX_WAYS'(hit_vec)));
    assign any_invalid     = ~&valid_out;
    assign invalid_way     = WAY_W'(lowest_set_index(MAX_WAYS'(~valid_out)));
    assign miss_victim     = any_invalid ? invalid_way : plru_victim;
    assign victim_needs_wb = valid_out[miss_victim] & dirty_out[miss_victim];

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_mask
        assign hit_mask[gi]    = (hit_way == WAY_W'(gi));
        assign victim_mask[gi] = (victim_reg == WAY_W'(gi));
    end

    plru_tree #(.WAYS(WAYS)) u_plru (
        .bits_in    (plru_bits_in),
        .access_way (hit_way),
        .bits_out   (plru_updated),
        .victim_way (plru_victim)
    );

    // State transitions and victim capture on a miss.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            victim_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req) state_reg <= CHECK;
                end
                CHECK: begin
                    if (!req) begin
                        state_reg <= IDLE;
                    end else if (hit) begin
`ifdef CACHE_CTRL_BACK2BACK_EN
                        state_reg <= CHECK;
`else
                        state_reg <= IDLE;
`endif
                    end else begin
                        victim_reg <= miss_victim;
                        state_reg  <= victim_needs_wb ? WRITEBACK : FILL;
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) state_reg <= FILL;
                end
                FILL: begin
                    if (pmem_resp) state_reg <= CHECK;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Datapath and memory controls decoded from state and lookup result.
    always_comb begin
        mem_resp_cpu  = 1'b0;
        plru_bits_out = '0;
        ld_plru       = 1'b0;
        ld_tag        = '0;
        ld_valid      = '0;
        valid_in      = 1'b0;
        ld_dirty      = '0;
        dirty_in      = 1'b0;
        data_we       = '0;
        data_src_mem  = 1'b0;
        way_sel       = (state_reg == CHECK) ? hit_way : victim_reg;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_addr_sel = 1'b0;
        case (state_reg)
            CHECK: begin
                if (req && hit) begin
                    mem_resp_cpu  = 1'b1;
                    ld_plru       = 1'b1;
                    plru_bits_out = plru_updated;
                    if (mem_write_cpu) begin
                        data_we  = hit_mask;
                        ld_dirty = hit_mask;
                        dirty_in = 1'b1;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
                if (pmem_resp) ld_dirty = victim_mask;
            end
            FILL: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    data_we      = victim_mask;
                    data_src_mem = 1'b1;
                    ld_tag       = victim_mask;
                    ld_valid     = victim_mask;
                    valid_in     = 1'b1;
                    ld_dirty     = victim_mask;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_control_nway.sv
// Scoreboard bench for cache_control_nway (WAYS=4). Stimulus pushes the
// expected output snapshot for every cycle in which the controller should
// assert a completion or array write; the monitor pops and compares.
module tb_cache_control_nway;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_read_cpu, mem_write_cpu, mem_resp_cpu;
    logic [3:0] hit_vec, valid_out, dirty_out;
    logic [2:0] plru_bits_in, plru_bits_out;
    logic       ld_plru;
    logic [3:0] ld_tag, ld_valid, ld_dirty, data_we;
    logic       valid_in, dirty_in, data_src_mem;
    logic [1:0] way_sel;
    logic       pmem_read, pmem_write, pmem_addr_sel, pmem_resp;

    int checks   = 0;
    int failures = 0;
    logic [28:0] exp_q[$];
    logic [28:0] act_vec;

    always #5 clk = ~clk;

    cache_control_nway #(.WAYS(4)) dut (
        .clk(clk), .rst(rst),
        .mem_read_cpu(mem_read_cpu), .mem_write_cpu(mem_write_cpu),
        .mem_resp_cpu(mem_resp_cpu), .hit_vec(hit_vec),
        .valid_out(valid_out), .dirty_out(dirty_out),
        .plru_bits_in(plru_bits_in), .plru_bits_out(plru_bits_out),
        .ld_plru(ld_plru), .ld_tag(ld_tag), .ld_valid(ld_valid),
        .valid_in(valid_in), .ld_dirty(ld_dirty), .dirty_in(dirty_in),
        .data_we(data_we), .data_src_mem(data_src_mem), .way_sel(way_sel),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_addr_sel(pmem_addr_sel), .pmem_resp(pmem_resp)
    );

    assign act_vec = {mem_resp_cpu, ld_plru, plru_bits_out, ld_tag, ld_valid, valid_in,
                      ld_dirty, dirty_in, data_we, data_src_mem, way_sel,
                      pmem_read, pmem_write, pmem_addr_sel};

    function automatic logic [28:0] mk(
        input logic resp, input logic lp, input logic [2:0] plru,
        input logic [3:0] tag, input logic [3:0] vld, input logic vin,
        input logic [3:0] dty, input logic din, input logic [3:0] we,
        input logic src, input logic [1:0] way,
        input logic pr, input logic pw, input logic pas);
        return {resp, lp, plru, tag, vld, vin, dty, din, we, src, way, pr, pw, pas};
    endfunction

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: any completion or array write must match the next expectation.
    always @(negedge clk) begin
        if (mem_resp_cpu || ld_plru || (|ld_tag) || (|ld_valid) || (|ld_dirty) || (|data_we)) begin
            $display("txn t=%0t out=%h", $time, act_vec);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got %h expected none at %0t", act_vec, $time);
            end else begin
                check("sb_output", 32'(act_vec), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_req();
        mem_read_cpu  = 1'b0;
        mem_write_cpu = 1'b0;
        hit_vec       = 4'b0000;
        pmem_resp     = 1'b0;
    endtask

    // One hit transaction starting from IDLE.
    task automatic do_hit(input logic wr, input logic [3:0] hv, input logic [2:0] pin,
                          input logic [2:0] exp_plru, input logic [3:0] wmask,
                          input logic [1:0] way);
        tick();
        mem_read_cpu  = ~wr;
        mem_write_cpu = wr;
        hit_vec       = hv;
        plru_bits_in  = pin;
        valid_out     = 4'b1111;
        exp_q.push_back(mk(1'b1, 1'b1, exp_plru, 4'b0, 4'b0, 1'b0, wmask, wr, wmask,
                           1'b0, way, 1'b0, 1'b0, 1'b0));
        sample();
        check("idle_no_resp", 32'(mem_resp_cpu), 32'd0);
        tick();
        sample();
        check("hit_resp", 32'(mem_resp_cpu), 32'd1);
        tick();
        clear_req();
        sample();
    endtask

    int rc[3];
    int n;
    int exp_gap;

    initial begin
        rst = 1'b1;
        clear_req();
        valid_out    = 4'b0000;
        dirty_out    = 4'b0000;
        plru_bits_in = 3'b000;
        tick();
        tick();
        sample();
        check("reset_outputs", 32'(act_vec), 32'd0);
        rst = 1'b0;

        // Read hit on way 1, write hits on way 3 and way 0, multi-hit picks lowest.
        do_hit(1'b0, 4'b0010, 3'b000, 3'b001, 4'b0000, 2'd1);
        do_hit(1'b1, 4'b1000, 3'b111, 3'b010, 4'b1000, 2'd3);
        do_hit(1'b0, 4'b0110, 3'b110, 3'b101, 4'b0000, 2'd1);
        do_hit(1'b1, 4'b0001, 3'b000, 3'b011, 4'b0001, 2'd0);

        // Clean miss: way 2 invalid is chosen, fill takes 5 wait cycles.
        tick();
        mem_read_cpu = 1'b1;
        hit_vec      = 4'b0000;
        valid_out    = 4'b1011;
        dirty_out    = 4'b1011;
        plru_bits_in = 3'b000;
        sample();
        tick();
        sample();
        check("miss_no_resp", 32'(mem_resp_cpu), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            sample();
            check("fill_pmem", 32'({pmem_read, pmem_write, pmem_addr_sel}), 32'(3'b100));
            check("fill_way_sel", 32'(way_sel), 32'd2);
        end
        tick();
        pmem_resp = 1'b1;
        exp_q.push_back(mk(1'b0, 1'b0, 3'b000, 4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b0,
                           4'b0100, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0));
        sample();
        tick();
        pmem_resp = 1'b0;
        hit_vec   = 4'b0100;
        valid_out = 4'b1111;
        exp_q.push_back(mk(1'b1, 1'b1, 3'b100, 4'b0, 4'b0, 1'b0, 4'b0, 1'b0, 4'b0,
                           1'b0, 2'd2, 1'b0, 1'b0, 1'b0));
        sample();
        check("recheck_resp", 32'(mem_resp_cpu), 32'd1);
        tick();
        clear_req();
        sample();

        // Dirty miss via PLRU (3'b011 -> way 2), write request.
        tick();
        mem_write_cpu = 1'b1;
        hit_vec       = 4'b0000;
        valid_out     = 4'b1111;
        dirty_out     = 4'b0100;
        plru_bits_in  = 3'b011;
        sample();
        tick();
        sample();
        check("dmiss_no_resp", 32'(mem_resp_cpu), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            sample();
            check("wb_pmem", 32'({pmem_read, pmem_write, pmem_addr_sel}), 32'(3'b011));
        end
        tick();
        pmem_resp = 1'b1;
        exp_q.push_back(mk(1'b0, 1'b0, 3'b000, 4'b0, 4'b0, 1'b0, 4'b0100, 1'b0, 4'b0,
                           1'b0, 2'd2, 1'b0, 1'b1, 1'b1));
        sample();
        for (int i = 0; i < 2; i++) begin
            tick();
            pmem_resp = 1'b0;
            sample();
            check("wb_then_fill_pmem", 32'({pmem_read, pmem_write, pmem_addr_sel}), 32'(3'b100));
        end
        tick();
        pmem_resp = 1'b1;
        exp_q.push_back(mk(1'b0, 1'b0, 3'b000, 4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b0,
                           4'b0100, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0));
        sample();
        tick();
        pmem_resp = 1'b0;
        hit_vec   = 4'b0100;
        exp_q.push_back(mk(1'b1, 1'b1, 3'b110, 4'b0, 4'b0, 1'b0, 4'b0100, 1'b1, 4'b0100,
                           1'b0, 2'd2, 1'b0, 1'b0, 1'b0));
        sample();
        check("dmiss_recheck_resp", 32'(mem_resp_cpu), 32'd1);
        tick();
        clear_req();
        sample();

        // Reset asserted for two edges in the middle of a fill.
        tick();
        mem_read_cpu = 1'b1;
        hit_vec      = 4'b0000;
        valid_out    = 4'b0111;
        dirty_out    = 4'b0000;
        sample();
        tick();
        sample();
        tick();
        sample();
        check("pre_reset_fill", 32'(pmem_read), 32'd1);
        tick();
        rst = 1'b1;
        sample();
        tick();
        sample();
        check("reset_mid_fill", 32'(act_vec), 32'd0);
        tick();
        rst = 1'b0;
        clear_req();
        sample();
        check("reset_release", 32'(act_vec), 32'd0);
        tick();
        sample();
        check("post_reset_idle", 32'(act_vec), 32'd0);

        // Three consecutive read hits with the request held.
`ifdef CACHE_CTRL_BACK2BACK_EN
        exp_gap = 2;
`else
        exp_gap = 4;
`endif
        tick();
        mem_read_cpu = 1'b1;
        hit_vec      = 4'b0001;
        plru_bits_in = 3'b000;
        valid_out    = 4'b1111;
        for (int i = 0; i < 3; i++)
            exp_q.push_back(mk(1'b1, 1'b1, 3'b011, 4'b0, 4'b0, 1'b0, 4'b0, 1'b0, 4'b0,
                               1'b0, 2'd0, 1'b0, 1'b0, 1'b0));
        n = 0;
        rc[0] = 0; rc[1] = 0; rc[2] = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            sample();
            if (mem_resp_cpu) begin
                rc[n] = k;
                n++;
                if (n == 3) break;
            end
        end
        check("b2b_count", 32'(n), 32'd3);
        check("b2b_span", 32'(rc[2] - rc[0]), 32'(exp_gap));
        tick();
        clear_req();
        sample();

        repeat (3) tick();
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cache_control_nway.md
Name: cache_control_nway

Overview:
- Parametrised N-way set-associative cache controller FSM; successor to the fixed 2-way controller.
- Sits between the CPU-side request interface and the cache datapath (tag/data/valid/dirty/PLRU arrays) plus physical memory.
- Adds configurable associativity, tree pseudo-LRU replacement, and invalid-way-first victim selection.
- Latches the victim across the miss sequence so the datapath sees a stable way index.

Parameters:
- WAYS, 4, associativity; power of two, >= 2.
- WAY_W, $clog2(WAYS), localparam; way index width.
- PLRU_W, WAYS-1, localparam; PLRU tree bits per set.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_read_cpu  in  1  CPU read request, held until mem_resp_cpu
- mem_write_cpu  in  1  CPU write request, held until mem_resp_cpu
- mem_resp_cpu  out  1  one-cycle request completion
- hit_vec  in  WAYS  per-way tag-match AND valid, from datapath
- valid_out  in  WAYS  valid bits of indexed set
- dirty_out  in  WAYS  dirty bits of indexed set
- plru_bits_in  in  PLRU_W  PLRU state of indexed set
- plru_bits_out  out  PLRU_W  updated PLRU state
- ld_plru  out  1  PLRU array write enable
- ld_tag  out  WAYS  tag write enable per way
- ld_valid  out  WAYS  valid write enable per way
- valid_in  out  1  valid write value
- ld_dirty  out  WAYS  dirty write enable per way
- dirty_in  out  1  dirty write value
- data_we  out  WAYS  data-array write enable per way
- data_src_mem  out  1  data write source: 1 = pmem line, 0 = CPU write data
- way_sel  out  WAY_W  way driven to the read mux: hit way in CHECK, victim otherwise
- pmem_read  out  1  line-fill request
- pmem_write  out  1  writeback request
- pmem_addr_sel  out  1  1 = victim tag + index, 0 = CPU address
- pmem_resp  in  1  memory completion

Behaviour:
- Reset:
  - State is IDLE; victim register is 0.
  - Every output is 0 from the cycle following the reset edge.
  - Reset mid-miss abandons the pmem transaction without a response.
- Requests: `req = mem_read_cpu | mem_write_cpu`. Simultaneous read and write is illegal; write takes priority.
- IDLE: req -> CHECK.
- CHECK, hit (hit_vec != 0):
  - Hit way h is the lowest set index.
  - Same cycle: mem_resp_cpu = 1, ld_plru = 1, plru_bits_out = update(plru_bits_in, h).
  - Write hit also drives data_we[h] = 1, ld_dirty[h] = 1, dirty_in = 1, data_src_mem = 0.
  - Next state: IDLE.
- CHECK, miss:
  - Victim is the lowest-index invalid way if any; otherwise the PLRU victim of plru_bits_in.
  - The victim is registered at the clock edge.
  - Next state: WRITEBACK if the victim is valid and dirty, else FILL.
  - No mem_resp_cpu.
- CHECK, no req (request withdrawn): -> IDLE, no outputs.
- WRITEBACK:
  - pmem_write = 1 and pmem_addr_sel = 1 until pmem_resp.
  - On pmem_resp: ld_dirty[victim] = 1, dirty_in = 0; -> FILL.
- FILL:
  - pmem_read = 1 and pmem_addr_sel = 0 until pmem_resp.
  - On pmem_resp: data_we[victim] = 1, data_src_mem = 1, ld_tag[victim] = 1, ld_valid[victim] = 1, valid_in = 1, ld_dirty[victim] = 1, dirty_in = 0; -> CHECK.
  - The re-check then hits and updates PLRU.
- Request dropped during WRITEBACK/FILL: the sequence completes; CHECK then goes to IDLE.
- Latency: hit resolves 1 cycle after the request is seen in IDLE; clean miss = 2 + fill latency + 1.
- PLRU tree:
  - Heap-ordered: node i has children 2i+1 and 2i+2; bit 0 is the root.
  - Bit value 0 points the victim toward lower way indices, 1 toward higher.
  - On access to way w, every node on w's path is set to point away from w; off-path bits are unchanged.

Optional Feature:
- Macro CACHE_CTRL_BACK2BACK_EN.
- Defined: a hit in CHECK stays in CHECK when req is still asserted the next cycle, giving one hit per cycle; CHECK with no req goes to IDLE.
- Undefined: a hit always returns to IDLE, with one bubble per request.

Decomposition:
- Package cache_ctrl_pkg:
  - state enum {IDLE, CHECK, WRITEBACK, FILL}.
  - PLRU direction constants.
  - Function lowest_set_index.
- Sub-module plru_tree, parametrised by WAYS:
  - Purely combinational.
  - Inputs: bits_in, access_way.
  - Outputs: bits_out (updated tree) and victim_way (tree walk).

Test Plan (WAYS=4):
- Reset: rst high 2 cycles mid-FILL -> state IDLE, pmem_read = 0 and all outputs 0 the next cycle, no mem_resp_cpu.
- Read hit: hit_vec = 4'b0010, plru_bits_in = 3'b000 -> mem_resp_cpu in CHECK, ld_plru = 1, plru_bits_out = 3'b001, data_we = 0.
- Write hit: hit_vec = 4'b1000 -> data_we = 4'b1000, ld_dirty = 4'b1000, dirty_in = 1, data_src_mem = 0, mem_resp_cpu = 1.
- Clean miss, invalid way:
  - Stimulus: valid_out = 4'b1011, dirty_out = 4'b1011, pmem_resp after 5 cycles.
  - Response: victim 2, no WRITEBACK, pmem_read high 5 cycles; on pmem_resp ld_tag = ld_valid = 4'b0100, valid_in = 1; then CHECK hit -> mem_resp_cpu.
- Dirty miss via PLRU:
  - Stimulus: valid_out = 4'b1111, dirty_out = 4'b0100, plru_bits_in = 3'b011.
  - Response: victim 2 -> WRITEBACK with pmem_write = 1, pmem_addr_sel = 1; on pmem_resp ld_dirty = 4'b0100, dirty_in = 0 -> FILL.
- Back-to-back (CACHE_CTRL_BACK2BACK_EN defined): 3 consecutive read hits -> mem_resp_cpu high 3 consecutive cycles, no return to IDLE; undefined -> resp every other cycle.
